// File: rtl/demux_tdm_pkg.sv
// rtl/demux_tdm_pkg.sv - shared constants and framing state type for the TDM receiver
package demux_tdm_pkg;
  localparam int SLOT_COUNT = 8;
  localparam int SLOT_W = 3;
  localparam logic [SLOT_W-1:0] FIRST_SLOT = 3'd0;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 3'd7;

  typedef enum logic {HUNT, COLLECT} state_t;
endpackage

// File: rtl/tdm_slot_tracker.sv
// rtl/tdm_slot_tracker.sv - framing FSM tracking the expected next slot of a 0..7 sweep
module tdm_slot_tracker
  import demux_tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [SLOT_W-1:0] select_lines,
  output logic              accept,
  output logic              restart,
  output logic              last,
  output logic              error
);
  state_t            r_state;
  logic [SLOT_W-1:0] r_exp;
  logic              w_is_first;
  logic              w_in_seq;

  // r_exp is never FIRST_SLOT while collecting, so slot 0 in COLLECT is always an error+restart
  assign w_is_first = (select_lines == FIRST_SLOT);
  assign w_in_seq   = (r_state == COLLECT) && (select_lines == r_exp);
  assign restart    = in_valid && w_is_first;
  assign error      = in_valid && (r_state == COLLECT) && !w_in_seq;
  assign accept     = restart || (in_valid && w_in_seq);
  assign last       = in_valid && w_in_seq && (r_exp == LAST_SLOT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_exp   <= FIRST_SLOT;
    end else if (in_valid) begin
      if (restart) begin
        r_state <= COLLECT;
        r_exp   <= FIRST_SLOT + 3'd1;
      end else if (w_in_seq) begin
        if (r_exp == LAST_SLOT) begin
          r_state <= HUNT;
          r_exp   <= FIRST_SLOT;
        end else begin
          r_exp <= r_exp + 3'd1;
        end
      end else if (r_state == COLLECT) begin
        r_state <= HUNT;
        r_exp   <= FIRST_SLOT;
      end
    end
  end
endmodule

// File: rtl/demultiplexer_1_to_8_tdm_receiver.sv
// rtl/demultiplexer_1_to_8_tdm_receiver.sv - 1-to-8 TDM demux with in-order frame reassembly
module demultiplexer_1_to_8_tdm_receiver
  import demux_tdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_line,
  input  logic [SLOT_W-1:0]     select_lines,
  input  logic                  in_valid,
  output logic [SLOT_COUNT-1:0] live_lines,
  output logic [SLOT_COUNT-1:0] output_lines,
  output logic                  frame_valid,
  output logic                  slot_error
);
  logic                  w_accept;
  logic                  w_restart;
  logic                  w_last;
  logic                  w_error;
  logic [SLOT_COUNT-1:0] r_shadow;
  logic [SLOT_COUNT-1:0] r_live;
  logic [SLOT_COUNT-1:0] r_frame;
  logic                  r_frame_valid;
  logic                  r_slot_error;

  tdm_slot_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .select_lines (select_lines),
    .accept       (w_accept),
    .restart      (w_restart),
    .last         (w_last),
    .error        (w_error)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live        <= '0;
      r_shadow      <= '0;
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
      r_slot_error  <= 1'b0;
    end else begin
      r_frame_valid <= w_last;
      r_slot_error  <= w_error;
      if (in_valid) r_live[select_lines] <= in_line;
      if (w_accept) r_shadow[select_lines] <= in_line;
      // Slot 7 bypasses the shadow so the frame lands the same cycle as the strobe
      if (w_last) r_frame <= {in_line, r_shadow[SLOT_COUNT-2:0]};
    end
  end

  assign live_lines   = r_live;
  assign output_lines = r_frame;
  assign frame_valid  = r_frame_valid;
  assign slot_error   = r_slot_error;
endmodule
